// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command scheduler.
// Holds the FSM state encoding and the status bytes returned to the host.
package serial_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GAP    = 3'd1,
      S_DECODE = 3'd2,
      S_ACK    = 3'd3,
      S_DRAIN  = 3'd4,
      S_RSP0   = 3'd5,
      S_RSP1   = 3'd6
   } state_t;

   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_DEC_ERR = 8'hEE;
   localparam logic [7:0] STATUS_TIMEOUT = 8'hEF;

   function automatic logic [7:0] sat_sub(
      input logic [7:0] a,
      input logic [7:0] b
   );
      return (a > b) ? (a - b) : 8'd0;
   endfunction

endpackage

// File: rtl/serial_frame_gap_detector.sv
// Frame-end detector: counts idle cycles since the last RX push and
// commits the frame on a long enough gap or a full FIFO.
module serial_frame_gap_detector #(
   parameter int SIZE_WIDTH      = 5,
   parameter int MAX_FRAME_BYTES = 16,
   parameter int IDLE_GAP_CYCLES = 5000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  active,
   input  logic                  rx_push,
   input  logic [SIZE_WIDTH-1:0] rx_size,
   output logic                  frame_commit
);

   localparam int GW = (IDLE_GAP_CYCLES > 1) ? $clog2(IDLE_GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP_CYCLES - 1);

   logic [GW-1:0] gap_cnt;
   logic          size_hit;
   logic          gap_hit;

   always_ff @(posedge clk) begin
      if (!rst || !active || rx_push) begin
         gap_cnt <= '0;
      end else if (gap_cnt != GAP_LAST) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // Size check wins over a push landing in the same cycle.
   assign size_hit     = (rx_size >= SIZE_WIDTH'(MAX_FRAME_BYTES));
   assign gap_hit      = (gap_cnt == GAP_LAST);
   assign frame_commit = active & (size_hit | gap_hit);

endmodule

// File: rtl/serial_cmd_scheduler.sv
// Serial command path sequencer: frame detect, decode handshake, drain, reply.
// Optional SERIAL_CMD_SCHEDULER_STATS_EN adds stat_ok/stat_err counters.
module serial_cmd_scheduler
   import serial_cmd_pkg::*;
#(
   parameter int SIZE_WIDTH      = 5,
   parameter int MAX_FRAME_BYTES = 16,
   parameter int IDLE_GAP_CYCLES = 5000,
   parameter int DECODE_TIMEOUT  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_push,
   input  logic                  rx_empty,
   input  logic [SIZE_WIDTH-1:0] rx_size,
   output logic                  rx_pop,
   input  logic                  dec_read_clk,
   output logic                  cmd_ready,
   input  logic                  cmd_processed,
   input  logic                  cmd_decode_success,
   input  logic [7:0]            cmd_bytes_processed,
   output logic                  cmd_processed_received,
   input  logic                  tx_full,
   output logic                  tx_push,
   output logic [7:0]            tx_data,
   output logic                  busy
`ifdef SERIAL_CMD_SCHEDULER_STATS_EN
   ,
   output logic [15:0]           stat_ok,
   output logic [15:0]           stat_err
`endif
);

   localparam int TW = (DECODE_TIMEOUT > 1) ? $clog2(DECODE_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(DECODE_TIMEOUT - 1);

   state_t                state;
   state_t                state_n;
   logic [SIZE_WIDTH-1:0] frame_len;
   logic [7:0]            status;
   logic [7:0]            count;
   logic [7:0]            residual;
   logic [TW-1:0]         to_cnt;
   logic                  drain_wait;
   logic                  drain_pulse;
   logic                  frame_commit;
   logic                  to_hit;

   serial_frame_gap_detector #(
      .SIZE_WIDTH      (SIZE_WIDTH),
      .MAX_FRAME_BYTES (MAX_FRAME_BYTES),
      .IDLE_GAP_CYCLES (IDLE_GAP_CYCLES)
   ) u_gap (
      .clk          (clk),
      .rst          (rst),
      .active       (state == S_GAP),
      .rx_push      (rx_push),
      .rx_size      (rx_size),
      .frame_commit (frame_commit)
   );

   assign to_hit = (to_cnt == TO_LAST);

   always_comb begin
      state_n                = state;
      rx_pop                 = 1'b0;
      cmd_ready              = 1'b0;
      cmd_processed_received = 1'b0;
      tx_push                = 1'b0;
      tx_data                = 8'h00;
      drain_pulse            = 1'b0;
      busy                   = (state != S_IDLE);
      unique case (state)
         S_IDLE: begin
            if (!rx_empty) state_n = S_GAP;
         end
         S_GAP: begin
            if (frame_commit) state_n = S_DECODE;
         end
         S_DECODE: begin
            cmd_ready = 1'b1;
            rx_pop    = dec_read_clk & ~rx_empty;
            if (cmd_processed) begin
               state_n = S_ACK;
            end else if (to_hit) begin
               state_n = S_DRAIN;
            end
         end
         S_ACK: begin
            cmd_processed_received = 1'b1;
            if (!cmd_processed) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            // Pops are spaced one idle cycle apart so rx_empty settles.
            if (!drain_wait) begin
               if (residual == 8'd0 || rx_empty) begin
                  state_n = S_RSP0;
               end else begin
                  drain_pulse = 1'b1;
               end
            end
            rx_pop = drain_pulse;
         end
         S_RSP0: begin
            tx_data = status;
            tx_push = ~tx_full;
            if (!tx_full) state_n = S_RSP1;
         end
         S_RSP1: begin
            tx_data = count;
            tx_push = ~tx_full;
            if (!tx_full) state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         frame_len  <= '0;
         status     <= STATUS_OK;
         count      <= 8'h00;
         residual   <= 8'h00;
         to_cnt     <= '0;
         drain_wait <= 1'b0;
      end else begin
         state <= state_n;
         unique case (state)
            S_GAP: begin
               if (frame_commit) begin
                  frame_len <= rx_size;
                  to_cnt    <= '0;
               end
            end
            S_DECODE: begin
               to_cnt <= to_cnt + 1'b1;
               if (cmd_processed) begin
                  status <= cmd_decode_success ? STATUS_OK : STATUS_DEC_ERR;
                  count  <= cmd_bytes_processed;
               end else if (to_hit) begin
                  status     <= STATUS_TIMEOUT;
                  count      <= 8'h00;
                  residual   <= 8'(frame_len);
                  drain_wait <= 1'b0;
               end
            end
            S_ACK: begin
               if (!cmd_processed) begin
                  residual   <= (status == STATUS_OK) ? 8'd0 :
                                sat_sub(8'(frame_len), count);
                  drain_wait <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (drain_pulse) begin
                  residual   <= residual - 8'd1;
                  drain_wait <= 1'b1;
               end else begin
                  drain_wait <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SERIAL_CMD_SCHEDULER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_ok  <= 16'h0000;
         stat_err <= 16'h0000;
      end else if (state == S_RSP1 && !tx_full) begin
         if (status == STATUS_OK) begin
            if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
         end else begin
            if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
         end
      end
   end
`endif

endmodule
